// File: rtl/int_writeback.sv
// -----------------------------------------------------------------------------
// int_writeback
//
// Integer writeback stage and long-latency register scoreboard. Merges the
// single-cycle ALU result path and the multi-cycle long unit (mul/div/load)
// into the one register-file write port. It also tracks destinations with
// outstanding long results so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_wdata     ALU result (no backpressure, top priority)
//   long_valid/long_ready          long-unit result handshake
//   long_rd/long_wdata             long-unit destination and data
//   iss_valid/iss_long/iss_rd      instruction issuing from decode
//   iss_rs1/iss_rs2                sources of the issuing instruction
//   iss_use_rs1/iss_use_rs2        source-used qualifiers
//   stall                          combinational hazard to decode
//   rd_wen/rd_addr/rd_wdata        registered register-file write port
//   busy                           scoreboard, bit r = x[r] outstanding
//
// Optional feature macro: INT_WRITEBACK_TRACE_EN (simulation trace of loaded
// writes and of issue attempts made while stalled; no effect on logic).
// -----------------------------------------------------------------------------
module int_writeback #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  input  logic            long_valid,
  output logic            long_ready,
  input  logic [4:0]      long_rd,
  input  logic [XLEN-1:0] long_wdata,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_use_rs1,
  input  logic            iss_use_rs2,
  output logic            stall,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  output logic [31:0]     busy
);

  logic        long_xfer;
  logic        raw_hazard;
  logic        waw_hazard;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] busy_next;

  // Arbitration and hazard detection; stall looks only at registered busy,
  // so a result completing this cycle releases the stall one cycle later.
  always_comb begin
    long_ready = !alu_valid;
    long_xfer  = long_valid && !alu_valid;
    raw_hazard = iss_valid && ((iss_use_rs1 && busy[iss_rs1]) ||
                               (iss_use_rs2 && busy[iss_rs2]));
    waw_hazard = iss_valid && busy[iss_rd];
    stall      = raw_hazard || waw_hazard;
  end

  // Scoreboard next state; x0 is never tracked and set wins over clear.
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (iss_valid && iss_long && !stall && (iss_rd != 5'd0)) begin
      set_vec[iss_rd] = 1'b1;
    end else begin
      set_vec = 32'd0;
    end
    if (long_xfer && (long_rd != 5'd0)) begin
      clr_vec[long_rd] = 1'b1;
    end else begin
      clr_vec = 32'd0;
    end
    busy_next = (busy & ~clr_vec) | set_vec;
  end

  // Write-port register and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_wen   <= 1'b0;
      rd_addr  <= 5'd0;
      rd_wdata <= {XLEN{1'b0}};
      busy     <= 32'd0;
    end else begin
      busy <= busy_next;
      if (alu_valid) begin
        rd_wen   <= 1'b1;
        rd_addr  <= alu_rd;
        rd_wdata <= alu_wdata;
      end else if (long_xfer) begin
        rd_wen   <= 1'b1;
        rd_addr  <= long_rd;
        rd_wdata <= long_wdata;
      end else begin
        // Address and data hold so the port only toggles on real writes.
        rd_wen <= 1'b0;
      end
    end
  end

`ifdef INT_WRITEBACK_TRACE_EN
  // Simulation trace of each loaded write and of issue attempts under stall.
  always @(posedge clk) begin
    if (rst_n) begin
      if (alu_valid) begin
        $display("%0t int_writeback: alu  x%0d <= 0x%h (%0d)", $time, alu_rd, alu_wdata, alu_wdata);
      end else if (long_xfer) begin
        $display("%0t int_writeback: long x%0d <= 0x%h (%0d)", $time, long_rd, long_wdata, long_wdata);
      end
      if (iss_valid && stall) begin
        $display("%0t int_writeback: issue attempted while stalled (rd=x%0d)", $time, iss_rd);
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_writeback.sv
// -----------------------------------------------------------------------------
// tb_int_writeback
//
// Directed self-checking bench for int_writeback. Inputs change 1 time unit
// after a rising edge; outputs are sampled there too, well away from the edge.
// -----------------------------------------------------------------------------
module tb_int_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        long_valid;
  logic        long_ready;
  logic [4:0]  long_rd;
  logic [31:0] long_wdata;
  logic        iss_valid;
  logic        iss_long;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_use_rs1;
  logic        iss_use_rs2;
  logic        stall;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [31:0] busy;

  int vectors    = 0;
  int miscompares = 0;

  int_writeback #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .long_valid(long_valid), .long_ready(long_ready),
    .long_rd(long_rd), .long_wdata(long_wdata),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
    .stall(stall),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'h0000_1234;
    long_valid = 1'b0; long_rd = 5'd0; long_wdata = 32'd0;
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
    iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_use_rs1 = 1'b0; iss_use_rs2 = 1'b0;

    // Reset held two cycles with an ALU result present: nothing recorded.
    tick();
    check("rst1_wen",   {31'd0, rd_wen}, 32'd0);
    check("rst1_addr",  {27'd0, rd_addr}, 32'd0);
    check("rst1_busy",  busy, 32'd0);
    check("rst_lready", {31'd0, long_ready}, 32'd0);
    tick();
    check("rst2_wen",   {31'd0, rd_wen}, 32'd0);
    check("rst2_data",  rd_wdata, 32'd0);

    // Release; ALU write of x5 appears one cycle later.
    rst_n = 1'b1; alu_wdata = 32'hDEAD_BEEF;
    tick();
    check("alu_wen",  {31'd0, rd_wen}, 32'd1);
    check("alu_addr", {27'd0, rd_addr}, 32'd5);
    check("alu_data", rd_wdata, 32'hDEAD_BEEF);
    alu_valid = 1'b0;
    tick();
    check("alu_idle_wen",  {31'd0, rd_wen}, 32'd0);
    check("alu_hold_addr", {27'd0, rd_addr}, 32'd5);
    check("alu_hold_data", rd_wdata, 32'hDEAD_BEEF);

    // Arbitration: ALU x3 wins, long x7 waits one cycle.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wdata = 32'h0000_0033;
    long_valid = 1'b1; long_rd = 5'd7; long_wdata = 32'h0000_0077;
    #1;
    check("arb_lready0", {31'd0, long_ready}, 32'd0);
    tick();
    check("arb_x3_addr", {27'd0, rd_addr}, 32'd3);
    check("arb_x3_data", rd_wdata, 32'h0000_0033);
    alu_valid = 1'b0;
    #1;
    check("arb_lready1", {31'd0, long_ready}, 32'd1);
    tick();
    check("arb_x7_wen",  {31'd0, rd_wen}, 32'd1);
    check("arb_x7_addr", {27'd0, rd_addr}, 32'd7);
    check("arb_x7_data", rd_wdata, 32'h0000_0077);
    long_valid = 1'b0;
    tick();
    check("arb_idle_wen", {31'd0, rd_wen}, 32'd0);

    // RAW: long x9 issued, then a reader of x9 stalls until after the transfer.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9;
    #1;
    check("raw_issue_stall", {31'd0, stall}, 32'd0);
    tick();
    check("raw_busy9", busy, 32'h0000_0200);
    iss_long = 1'b0; iss_rd = 5'd10; iss_rs1 = 5'd9; iss_use_rs1 = 1'b1;
    #1;
    check("raw_stall_a", {31'd0, stall}, 32'd1);
    tick();
    check("raw_stall_b", {31'd0, stall}, 32'd1);
    long_valid = 1'b1; long_rd = 5'd9; long_wdata = 32'h0000_0099;
    #1;
    check("raw_stall_xfer", {31'd0, stall}, 32'd1);
    tick();
    long_valid = 1'b0;
    check("raw_busy_clr",  busy, 32'd0);
    check("raw_stall_rel", {31'd0, stall}, 32'd0);
    check("raw_x9_addr",   {27'd0, rd_addr}, 32'd9);

    // rs2 path with use qualifier off then on.
    iss_valid = 1'b0; iss_use_rs1 = 1'b0;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd6;
    tick();
    check("rs2_busy6", busy, 32'h0000_0040);
    iss_long = 1'b0; iss_rd = 5'd11; iss_rs2 = 5'd6; iss_use_rs2 = 1'b0;
    #1;
    check("rs2_unused", {31'd0, stall}, 32'd0);
    iss_use_rs2 = 1'b1;
    #1;
    check("rs2_used", {31'd0, stall}, 32'd1);
    iss_valid = 1'b0; iss_use_rs2 = 1'b0;
    long_valid = 1'b1; long_rd = 5'd6; long_wdata = 32'h0000_0066;
    tick();
    long_valid = 1'b0;
    check("rs2_busy_clr", busy, 32'd0);

    // x0: long issue to x0 never marks busy.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
    tick();
    check("x0_busy", busy, 32'd0);

    // WAW: x4 busy blocks both ALU and long issues to x4.
    iss_rd = 5'd4;
    tick();
    check("waw_busy4", busy, 32'h0000_0010);
    iss_long = 1'b0;
    #1;
    check("waw_alu_stall", {31'd0, stall}, 32'd1);
    iss_long = 1'b1;
    tick();
    check("waw_long_stall", {31'd0, stall}, 32'd1);
    check("waw_busy_same",  busy, 32'h0000_0010);
    iss_valid = 1'b0;

    // Set and clear of x12 in the same cycle: set wins.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd12;
    long_valid = 1'b1; long_rd = 5'd12; long_wdata = 32'h0000_00CC;
    tick();
    iss_valid = 1'b0; long_valid = 1'b0;
    check("sc_busy12", busy, 32'h0000_1010);
    long_valid = 1'b1;
    tick();
    long_valid = 1'b0;
    check("sc_clear12", busy, 32'h0000_0010);

    // ALU write to x0 is still forwarded.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'hA5A5_0000;
    tick();
    check("x0_wen",  {31'd0, rd_wen}, 32'd1);
    check("x0_addr", {27'd0, rd_addr}, 32'd0);
    check("x0_data", rd_wdata, 32'hA5A5_0000);

    // Mid-operation reset: scoreboard cleared, pending write dropped.
    rst_n = 1'b0; alu_rd = 5'd2;
    #1;
    check("mrst_lready", {31'd0, long_ready}, 32'd0);
    tick();
    check("mrst_busy", busy, 32'd0);
    check("mrst_wen",  {31'd0, rd_wen}, 32'd0);
    check("mrst_addr", {27'd0, rd_addr}, 32'd0);
    rst_n = 1'b1; alu_valid = 1'b0;
    tick();
    check("post_wen", {31'd0, rd_wen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_writeback.md
# int_writeback

Integer writeback stage and register scoreboard, directly upstream of the integer register file write port. Merges results from the single-cycle ALU path and a multi-cycle long-latency unit (mul/div/load) into the one register-file write port (`rd_wen`/`rd_addr`/`rd_wdata`). Tracks destination registers with outstanding long-latency results so decode can stall on RAW/WAW hazards. The register file commits writes on the falling edge, so a value driven here in cycle N is readable by register-file reads sampled at the rising edge ending cycle N.

## Interface
Parameters:
- `XLEN`, 32, data width of results and write port.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; no backpressure.
- `alu_rd`  in  5  ALU destination register.
- `alu_wdata`  in  XLEN  ALU result.
- `long_valid`  in  1  long-unit result offered.
- `long_ready`  out  1  writeback accepts the long-unit result this cycle.
- `long_rd`  in  5  long-unit destination register.
- `long_wdata`  in  XLEN  long-unit result.
- `iss_valid`  in  1  decode is issuing an instruction this cycle.
- `iss_long`  in  1  issued instruction goes to the long unit.
- `iss_rd`  in  5  destination of the issued instruction.
- `iss_rs1`, `iss_rs2`  in  5 each  sources of the issuing instruction.
- `iss_use_rs1`, `iss_use_rs2`  in  1 each  source actually read.
- `stall`  out  1  combinational hazard; decode must not issue while high.
- `rd_wen`  out  1  register-file write enable (registered).
- `rd_addr`  out  5  register-file write address (registered).
- `rd_wdata`  out  XLEN  register-file write data (registered).
- `busy`  out  32  scoreboard; bit r set = result for x[r] outstanding in long unit.

## Operation
- Write arbitration: the ALU has fixed priority. `long_ready = !alu_valid`. A long transfer occurs when `long_valid && long_ready`.
- Write register: if `alu_valid`, load {1, `alu_rd`, `alu_wdata`}. Else if a long transfer occurs, load {1, `long_rd`, `long_wdata`}. Else `rd_wen` goes to 0; `rd_addr` and `rd_wdata` hold their values.
- A write to x0 is forwarded with `rd_wen`=1. The register file discards it. Scoreboard bit 0 is never set.
- Scoreboard set: `iss_valid && iss_long && !stall && iss_rd != 0` sets `busy[iss_rd]`.
- Scoreboard clear: a long transfer with `long_rd != 0` clears `busy[long_rd]`.
- Set and clear of the same bit in the same cycle leaves the bit set (set wins).
- `stall` is asserted when any of the following holds:
  - RAW: `iss_valid && ((iss_use_rs1 && busy[iss_rs1]) || (iss_use_rs2 && busy[iss_rs2]))`.
  - WAW: `iss_valid && busy[iss_rd]`. This applies to both ALU and long issues.
- `stall` uses the registered `busy` value. A result completing this cycle does not release the stall until the next cycle.
- Consequence of the stall rules: at most one outstanding long result per register. An ALU write can never target a busy register.
- Reset: `rd_wen`=0, `rd_addr`=0, `rd_wdata`=0, `busy`=0.
  - `long_ready` follows `alu_valid` even during reset.
  - Transfers presented while `rst_n`=0 are not recorded.

## Timing
- Write latency: one cycle. A result accepted in cycle N gives `rd_wen`=1 in cycle N+1 and is committed at the falling edge of N+1.
- A long result held off by the ALU stays on `long_*` (producer holds it stable) until accepted. Starvation requires back-to-back ALU results every cycle and is permitted.
- `busy` updates one cycle after the set or clear event.
- Reset mid-operation clears the scoreboard and drops any pending write. The long unit must be reset in the same cycle.

## Configuration
- `INT_WRITEBACK_TRACE_EN`:
  - Defined: each rising edge with a write being loaded prints `$time`, source (alu/long), rd, and wdata in hex and decimal. It also reports any attempt to issue while `stall`=1.
  - Undefined: no simulation output. RTL is otherwise identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `alu_valid`=1 → `rd_wen`=0, `busy`=0, `rd_addr`=0 throughout, first write appears only after release.
- ALU path: `alu_valid`=1, rd=5, data=0xDEADBEEF in cycle N → `rd_wen`=1, `rd_addr`=5, `rd_wdata`=0xDEADBEEF in N+1, `rd_wen`=0 in N+2.
- Arbitration: `alu_valid` and `long_valid` both high, rd=3/rd=7 → `long_ready`=0; x3 written in N+1, x7 in N+2 once ALU idle.
- RAW scoreboard: issue long rd=9; next instruction reads rs1=9 → `stall`=1 until the cycle after x9's long transfer, `busy[9]` cleared.
- WAW/x0: issue long rd=0 → `busy` stays 0. Issue ALU rd=4 while `busy[4]`=1 → `stall`=1.
- Same-cycle set/clear: long result for x12 accepted while a new long op to x12 issues → `busy[12]` remains 1. (The issue is stalled by the WAW rule, so it is forced via a bench with hazard override, or the bit is checked to stay clear-then-set across consecutive cycles.)
